// File: rtl/psum_writeback.sv
// Drains 8-lane partial-sum words from the output FIFO into the psum SRAM: overwrite on the first pass, read-modify-write accumulate after.
// Define PSUM_SAT_EN for saturating lane adds; by default the lane adds wrap.
module psum_writeback #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int addr_bw = 7,
   parameter int nij     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      first,
   input  logic [addr_bw-1:0]        base,
   input  logic [col*psum_bw-1:0]    of_out,
   input  logic                      of_valid,
   output logic                      of_rd,
   input  logic [col*psum_bw-1:0]    P_Q,
   output logic [col*psum_bw-1:0]    P_D,
   output logic [addr_bw-1:0]        P_A,
   output logic                      P_CEN,
   output logic                      P_WEN,
   output logic                      busy,
   output logic                      done
);

   localparam int word_bw = col * psum_bw;
   localparam int cnt_bw  = (nij > 1) ? $clog2(nij) : 1;
   localparam logic [cnt_bw-1:0] cnt_last = cnt_bw'(nij - 1);

   typedef enum logic [2:0] {IDLE, POP, RD, ACC, WR, DONE} state_t;

   state_t               state, state_nxt;
   logic                 first_r;
   logic [addr_bw-1:0]   base_r;
   logic [cnt_bw-1:0]    cnt;
   logic [word_bw-1:0]   word_r, sum_r, sum_nxt;
   logic [addr_bw-1:0]   addr;

   // Lanes are independent two's-complement adds; no carry crosses a lane boundary.
   function automatic logic [psum_bw-1:0] lane_add(input logic [psum_bw-1:0] a,
                                                   input logic [psum_bw-1:0] b);
`ifdef PSUM_SAT_EN
      logic [psum_bw:0] s;
      s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (s[psum_bw] != s[psum_bw-1])
         lane_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      else
         lane_add = s[psum_bw-1:0];
`else
      lane_add = a + b;
`endif
   endfunction

   // Address wraps modulo 2^addr_bw by construction of the adder width.
   assign addr = base_r + addr_bw'(cnt);

   always_comb begin
      sum_nxt = '0;
      for (int l = 0; l < col; l++)
         sum_nxt[l*psum_bw +: psum_bw] = lane_add(word_r[l*psum_bw +: psum_bw],
                                                  P_Q[l*psum_bw +: psum_bw]);
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
      state_nxt = state;
      of_rd     = 1'b0;
      P_CEN     = 1'b1;
      P_WEN     = 1'b1;
      P_A       = '0;
      P_D       = '0;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE: if (start) state_nxt = POP;
         POP: begin
            of_rd = of_valid;
            if (of_valid) state_nxt = first_r ? WR : RD;
         end
         RD: begin
            P_CEN     = 1'b0;
            P_A       = addr;
            state_nxt = ACC;
         end
         ACC: state_nxt = WR;
         WR: begin
            P_CEN     = 1'b0;
            P_WEN     = 1'b0;
            P_A       = addr;
            P_D       = first_r ? word_r : sum_r;
            state_nxt = (cnt == cnt_last) ? DONE : POP;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         first_r <= 1'b0;
         base_r  <= '0;
         cnt     <= '0;
         word_r  <= '0;
         sum_r   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               first_r <= first;
               base_r  <= base;
               cnt     <= '0;
            end
            POP: if (of_valid) word_r <= of_out;
            ACC: sum_r <= sum_nxt;
            WR:  if (cnt != cnt_last) cnt <= cnt + cnt_bw'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_writeback.sv
// Randomized scoreboard bench for psum_writeback: FIFO and SRAM models, spec-level reference memory, per-write comparison.
module tb_psum_writeback;
   localparam int COL   = 8;
   localparam int PBW   = 16;
   localparam int ABW   = 7;
   localparam int NIJ   = 16;
   localparam int WBW   = COL * PBW;
   localparam int DEPTH = 1 << ABW;

   typedef logic [WBW-1:0] word_t;
   typedef struct {
      logic [ABW-1:0] addr;
      word_t          data;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset, start, first;
   logic [ABW-1:0] base;
   word_t          of_out = '0;
   logic           of_valid = 1'b0;
   logic           of_rd;
   word_t          P_Q, P_D;
   logic [ABW-1:0] P_A;
   logic           P_CEN, P_WEN, busy, done;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // SRAM model with a side port for preloading
   word_t          sram [DEPTH];
   logic           pre_en = 1'b0;
   logic [ABW-1:0] pre_addr = '0;
   word_t          pre_data = '0;

   // FIFO model
   word_t stim [NIJ];
   int    pass_id = 0, seen_id = 0, rd_ptr = NIJ, pops_pass = 0;
   int    stall_at = 0, stall_start = -100;
   logic  stall = 1'b0, pop_s;

   // Reference model and scoreboard
   word_t          ref_mem [DEPTH];
   exp_t           exp_q [$];
   exp_t           e_cur;
   logic           active = 1'b0, m_first = 1'b0, m_stall = 1'b0;
   logic [ABW-1:0] m_base = '0, m_addr, rd_addr = '0;
   word_t          m_data;
   int             m_k = 0, wr_idx = 0, wr_cyc = 0, rd_cyc = 0;
   int             done_cnt = 0, lat = 0, start_cyc = 0;

   psum_writeback #(.col(COL), .psum_bw(PBW), .addr_bw(ABW), .nij(NIJ)) dut (
      .clk(clk), .reset(reset), .start(start), .first(first), .base(base),
      .of_out(of_out), .of_valid(of_valid), .of_rd(of_rd),
      .P_Q(P_Q), .P_D(P_D), .P_A(P_A), .P_CEN(P_CEN), .P_WEN(P_WEN),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input word_t act, input word_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic word_t splat(input logic [PBW-1:0] v);
      word_t r;
      for (int l = 0; l < COL; l++) r[l*PBW +: PBW] = v;
      return r;
   endfunction

   function automatic word_t rand_word();
      word_t r;
      for (int l = 0; l < COL; l++) r[l*PBW +: PBW] = PBW'($urandom);
      return r;
   endfunction

   // Lane-wise signed sum computed in plain integer arithmetic.
   function automatic word_t ref_acc(input word_t old, input word_t w);
      word_t r;
      int    s;
      for (int l = 0; l < COL; l++) begin
         s = int'($signed(old[l*PBW +: PBW])) + int'($signed(w[l*PBW +: PBW]));
`ifdef PSUM_SAT_EN
         if (s > (1 << (PBW-1)) - 1) s = (1 << (PBW-1)) - 1;
         if (s < -(1 << (PBW-1)))    s = -(1 << (PBW-1));
`endif
         r[l*PBW +: PBW] = s[PBW-1:0];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (pre_en) sram[pre_addr] <= pre_data;
      else if (!P_CEN) begin
         if (P_WEN) P_Q <= sram[P_A];
         else       sram[P_A] <= P_D;
      end
   end

   // FIFO: pop on the edge where of_rd was high, then present the new head.
   always @(posedge clk) begin
      pop_s = of_rd;
      #1;
      if (pass_id != seen_id) begin
         seen_id     = pass_id;
         rd_ptr      = 0;
         pops_pass   = 0;
         stall_start = -100;
      end else if (pop_s) begin
         rd_ptr++;
         pops_pass++;
         if (pops_pass == stall_at) stall_start = cyc + 1;
      end
      stall    = (cyc >= stall_start) && (cyc < stall_start + 3);
      of_valid = (rd_ptr < NIJ) && !stall;
      of_out   = (rd_ptr < NIJ) ? stim[rd_ptr] : '0;
   end

   // Monitor: expected writes are queued when a word is popped, compared when the DUT writes.
   always @(negedge clk) begin
      if (pre_en) ref_mem[pre_addr] = pre_data;
      if (!reset) begin
         exp_q.delete();
         active = 1'b0;
      end else begin
         if (start && !active) begin
            active    = 1'b1;
            m_first   = first;
            m_base    = base;
            m_k       = 0;
            wr_idx    = 0;
            done_cnt  = 0;
            start_cyc = cyc + 1;
            m_stall   = (stall_at != 0);
         end
         if (of_rd) begin
            check("of_rd_needs_valid", WBW'(of_valid), WBW'(1));
            if (active) begin
               m_addr = m_base + ABW'(m_k);
               m_data = m_first ? of_out : ref_acc(ref_mem[m_addr], of_out);
               ref_mem[m_addr] = m_data;
               exp_q.push_back('{addr: m_addr, data: m_data});
               m_k++;
            end
         end
         if (stall) begin
            check("stall_of_rd", WBW'(of_rd), WBW'(0));
            check("stall_cen", WBW'(P_CEN), WBW'(1));
            check("stall_busy", WBW'(busy), WBW'(1));
         end
         if (!P_CEN && P_WEN) begin
            rd_addr = P_A;
            rd_cyc  = cyc;
         end
         if (!P_CEN && !P_WEN) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: addr %0h data %0h with no word outstanding", P_A, P_D);
            end else begin
               e_cur = exp_q.pop_front();
               check("wr_addr", WBW'(P_A), WBW'(e_cur.addr));
               check("wr_data", P_D, e_cur.data);
               if (!m_first) begin
                  check("rmw_rd_addr", WBW'(rd_addr), WBW'(P_A));
                  check("rmw_rd_to_wr", WBW'(cyc - rd_cyc), WBW'(2));
               end
               if (wr_idx > 0 && !m_stall)
                  check("cycles_per_word", WBW'(cyc - wr_cyc), WBW'(m_first ? 2 : 4));
               wr_idx++;
               wr_cyc = cyc;
            end
         end
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) lat = cyc - start_cyc + 1;
            active = 1'b0;
         end
      end
   end

   task automatic preload(input int a, input word_t d);
      @(posedge clk); #2;
      pre_en   = 1'b1;
      pre_addr = ABW'(a);
      pre_data = d;
      @(posedge clk); #2;
      pre_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_of_rd"}, WBW'(of_rd), WBW'(0));
      check({tag, "_cen"},   WBW'(P_CEN), WBW'(1));
      check({tag, "_wen"},   WBW'(P_WEN), WBW'(1));
      check({tag, "_addr"},  WBW'(P_A),   WBW'(0));
      check({tag, "_data"},  P_D,         '0);
      check({tag, "_busy"},  WBW'(busy),  WBW'(0));
      check({tag, "_done"},  WBW'(done),  WBW'(0));
   endtask

   task automatic run_pass(input logic f, input logic [ABW-1:0] b, input int s_at,
                           input logic busy_start, input int exp_lat);
      logic [ABW-1:0] a;
      @(posedge clk); #2;
      pass_id++;
      stall_at = s_at;
      start    = 1'b1;
      first    = f;
      base     = b;
      @(posedge clk); #2;
      start = 1'b0;
      first = 1'($urandom);
      base  = ABW'($urandom);
      if (busy_start) begin
         repeat (3) @(posedge clk);
         #2;
         start = 1'b1;
         first = ~f;
         base  = b + ABW'(5);
         @(posedge clk); #2;
         start = 1'b0;
      end
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (done_cnt != 0) break;
      end
      repeat (3) @(posedge clk);
      #2;
      check("done_pulses", WBW'(done_cnt), WBW'(1));
      check("pass_latency", WBW'(lat), WBW'(exp_lat));
      check("pops_per_pass", WBW'(pops_pass), WBW'(NIJ));
      check("writes_per_pass", WBW'(wr_idx), WBW'(NIJ));
      check("idle_after_pass", WBW'(busy), WBW'(0));
      for (int k = 0; k < NIJ; k++) begin
         a = b + ABW'(k);
         check("sram_vs_model", sram[a], ref_mem[a]);
      end
      stall_at = 0;
   endtask

   initial begin
      logic f;
      reset = 1'b0;
      start = 1'b0;
      first = 1'b0;
      base  = '0;
      for (int k = 0; k < NIJ; k++) stim[k] = '0;
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      for (int a = 0; a < DEPTH; a++) preload(a, rand_word());
      @(posedge clk); #2;
      reset = 1'b1;

      // Overwrite pass: address k holds k in every lane
      for (int k = 0; k < NIJ; k++) stim[k] = splat(PBW'(k));
      run_pass(1'b1, 7'd0, 0, 1'b0, 2*NIJ + 1);
      for (int k = 0; k < NIJ; k++) check("t1_overwrite", sram[k], splat(PBW'(k)));

      // Accumulate pass: 100 + 5 in every lane
      for (int k = 0; k < NIJ; k++) preload(16 + k, splat(16'd100));
      for (int k = 0; k < NIJ; k++) stim[k] = splat(16'd5);
      run_pass(1'b0, 7'd16, 0, 1'b0, 4*NIJ + 1);
      for (int k = 0; k < NIJ; k++) check("t2_accumulate", sram[16 + k], splat(16'd105));

      // FIFO stall of 3 cycles after word 4
      for (int k = 0; k < NIJ; k++) stim[k] = rand_word();
      run_pass(1'b1, 7'd32, 4, 1'b0, 2*NIJ + 1 + 3);

      // Address wrap with a start pulse while busy
      for (int k = 0; k < NIJ; k++) stim[k] = rand_word();
      run_pass(1'b1, 7'd120, 0, 1'b1, 2*NIJ + 1);
      check("t4_wrap_127", sram[127], stim[7]);
      check("t4_wrap_0", sram[0], stim[8]);
      check("t4_wrap_7", sram[7], stim[15]);

      // Lane overflow at both ends of the signed range
      begin
         word_t pw, sw;
         pw = splat(16'd7);
         pw[0*PBW +: PBW] = 16'd1;
         pw[1*PBW +: PBW] = 16'hFFFF;
         sw = splat(16'd1000);
         sw[0*PBW +: PBW] = 16'h7FFF;
         sw[1*PBW +: PBW] = 16'h8000;
         preload(40, pw);
         stim[0] = sw;
         for (int k = 1; k < NIJ; k++) stim[k] = rand_word();
         run_pass(1'b0, 7'd40, 0, 1'b0, 4*NIJ + 1);
`ifdef PSUM_SAT_EN
         check("t5_lane0_pos", WBW'(sram[40][0*PBW +: PBW]), WBW'(16'h7FFF));
         check("t5_lane1_neg", WBW'(sram[40][1*PBW +: PBW]), WBW'(16'h8000));
`else
         check("t5_lane0_pos", WBW'(sram[40][0*PBW +: PBW]), WBW'(16'h8000));
         check("t5_lane1_neg", WBW'(sram[40][1*PBW +: PBW]), WBW'(16'h7FFF));
`endif
         for (int l = 2; l < COL; l++)
            check("t5_neighbour", WBW'(sram[40][l*PBW +: PBW]), WBW'(16'd1007));
      end

      // Reset after word 5, then a clean pass
      for (int k = 0; k < NIJ; k++) stim[k] = rand_word();
      @(posedge clk); #2;
      pass_id++;
      start = 1'b1;
      first = 1'b1;
      base  = 7'd64;
      @(posedge clk); #2;
      start = 1'b0;
      for (int i = 0; i < 200 && pops_pass < 5; i++) begin
         @(posedge clk); #2;
      end
      check("t6_reached_word5", WBW'(pops_pass), WBW'(5));
      reset = 1'b0;
      #1;
      check_reset_outputs("t6_midpass");
      @(posedge clk); #2;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      check("t6_no_pops_after_reset", WBW'(pops_pass), WBW'(5));
      check("t6_idle_after_reset", WBW'(busy), WBW'(0));
      for (int k = 0; k < NIJ; k++) stim[k] = rand_word();
      run_pass(1'b1, 7'd64, 0, 1'b0, 2*NIJ + 1);

      // Random passes
      for (int p = 0; p < 4; p++) begin
         f = 1'($urandom);
         for (int k = 0; k < NIJ; k++) stim[k] = rand_word();
         run_pass(f, ABW'($urandom), 0, 1'b0, f ? 2*NIJ + 1 : 4*NIJ + 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $fatal(1);
   end

endmodule
